// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : MiniMIPS PC owner; fetches 16-bit instructions over req/ready
//            and holds each one until the datapath retires it.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
   parameter int              PC_W     = 32,
   parameter int              INSTR_W  = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 imem_req,
   output logic [PC_W-1:0]      imem_addr,
   input  logic                 imem_ready,
   input  logic [INSTR_W-1:0]   imem_rdata,
   output logic [INSTR_W-1:0]   instr,
   output logic [3:0]           opcode,
   output logic                 instr_valid,
   input  logic                 exec_done,
   input  logic                 branch,
   input  logic                 branchne,
   input  logic                 zero,
   output logic [PC_W-1:0]      pc,
   output logic [CNT_W-1:0]     retire_cnt
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_FETCH = 2'd1;
   localparam logic [1:0] c_EXEC  = 2'd2;

   logic [1:0]          r_state;
   logic [1:0]          w_next_state;
   logic                r_req;
   logic [PC_W-1:0]     r_pc;
   logic [INSTR_W-1:0]  r_instr;
   logic                r_valid;
   logic [CNT_W-1:0]    r_cnt;

   logic                w_load;
   logic                w_retire;
   logic                w_req_nxt;
   logic                w_take;
   logic [PC_W-1:0]     w_offset;
   logic [PC_W-1:0]     w_pc_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:  w_next_state = c_FETCH;
         c_FETCH: if (imem_ready) w_next_state = c_EXEC;
         c_EXEC:  if (exec_done)  w_next_state = c_FETCH;
         default: w_next_state = c_IDLE;
      endcase
   end

   // Strobes are qualified by state so stray handshakes outside their phase do nothing.
   always_comb begin
      w_load    = (r_state == c_FETCH) && imem_ready;
      w_retire  = (r_state == c_EXEC) && exec_done;
      w_req_nxt = (w_next_state == c_FETCH);
   end

   assign w_take    = (branch & zero) | (branchne & ~zero);
   assign w_offset  = {{(PC_W-6){r_instr[5]}}, r_instr[5:0]};
   assign w_pc_next = r_pc + PC_W'(1) + (w_take ? w_offset : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req   <= 1'b0;
         r_pc    <= RESET_PC;
         r_instr <= '0;
         r_valid <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_req <= w_req_nxt;
         if (w_load) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
         end
         if (w_retire) begin
            r_pc    <= w_pc_next;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_valid <= 1'b0;
         end
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign instr       = r_instr;
   assign opcode      = r_instr[INSTR_W-1 -: 4];
   assign instr_valid = r_valid;
   assign retire_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed plus randomized bench for instr_fetch_unit against a
//            transaction-level PC / counter model.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic        instr_valid;
   logic        exec_done = 1'b0;
   logic        branch = 1'b0;
   logic        branchne = 1'b0;
   logic        zero = 1'b0;
   logic [31:0] pc;
   logic [15:0] retire_cnt;

   logic        s_req;
   logic [31:0] s_addr;
   logic [15:0] s_instr;
   logic [3:0]  s_opcode;
   logic        s_valid;
   logic [31:0] s_pc;
   logic [3:0]  s_cnt;

   int          tests = 0;
   int          fails = 0;

   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   logic [15:0] m_instr;

   instr_fetch_unit u_dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
      .instr_valid(instr_valid), .exec_done(exec_done), .branch(branch),
      .branchne(branchne), .zero(zero), .pc(pc), .retire_cnt(retire_cnt)
   );

   // Narrow-counter twin sharing all stimulus, so counter wrap is reachable quickly.
   instr_fetch_unit #(.CNT_W(4)) u_small (
      .clk(clk), .rst_n(rst_n), .imem_req(s_req), .imem_addr(s_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(s_instr), .opcode(s_opcode),
      .instr_valid(s_valid), .exec_done(exec_done), .branch(branch),
      .branchne(branchne), .zero(zero), .pc(s_pc), .retire_cnt(s_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_pc    = 32'd0;
      m_cnt   = 32'd0;
      m_instr = 16'd0;
   endtask

   // Asserts reset (optionally while exec_done/imem_ready are pending) and releases it.
   task automatic do_reset(input bit pending);
      if (pending) begin
         exec_done  = 1'b1;
         imem_ready = 1'b1;
         branch     = 1'b1;
         zero       = 1'b1;
      end
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_valid", instr_valid, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_pc", pc, 0);
      chk("rst_cnt", retire_cnt, 0);
      chk("rst_instr", instr, 0);
      tick();
      exec_done = 0; imem_ready = 0; branch = 0; zero = 0;
      rst_n = 1'b1;
      chk("idle_req", imem_req, 0);
      tick();
      chk("first_req", imem_req, 1);
      chk("first_addr", imem_addr, 0);
   endtask

   task automatic do_fetch(input logic [15:0] d, input int dly, input bit spur);
      for (int i = 0; i < dly; i++) begin
         chk("req_wait", imem_req, 1);
         chk("addr_wait", imem_addr, m_pc);
         if (spur) begin
            exec_done = 1; branch = 1; zero = 1;
         end
         tick();
         exec_done = 0; branch = 0; zero = 0;
         if (spur) begin
            chk("spur_done_pc", pc, m_pc);
            chk("spur_done_cnt", retire_cnt, m_cnt[15:0]);
         end
      end
      chk("req", imem_req, 1);
      chk("addr", imem_addr, m_pc);
      chk("valid_pre", instr_valid, 0);
      imem_ready = 1'b1;
      imem_rdata = d;
      tick();
      imem_ready = 1'b0;
      imem_rdata = 16'($urandom);
      m_instr = d;
      chk("instr_valid", instr_valid, 1);
      chk("instr", instr, d);
      chk("opcode", opcode, 32'(d[15:12]));
      chk("req_exec", imem_req, 0);
   endtask

   task automatic do_exec(input bit br, input bit bne, input bit z,
                          input int dly, input bit spur, input bit both);
      int  off;
      bit  take;
      for (int i = 0; i < dly; i++) begin
         if (spur) begin
            imem_ready = 1'b1;
            imem_rdata = ~m_instr;
         end
         tick();
         imem_ready = 1'b0;
         chk("hold_instr", instr, m_instr);
         chk("hold_valid", instr_valid, 1);
         chk("hold_req", imem_req, 0);
      end
      exec_done = 1'b1; branch = br; branchne = bne; zero = z;
      imem_ready = both;
      imem_rdata = ~m_instr;
      tick();
      exec_done = 0; branch = 0; branchne = 0; zero = 0; imem_ready = 0;
      take  = (br && z) || (bne && !z);
      off   = m_instr[5] ? int'(m_instr[5:0]) - 64 : int'(m_instr[5:0]);
      m_pc  = m_pc + 32'd1 + (take ? 32'(off) : 32'd0);
      m_cnt = m_cnt + 1;
      chk("next_req", imem_req, 1);
      chk("next_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("retired_valid", instr_valid, 0);
      chk("retire_cnt", retire_cnt, m_cnt[15:0]);
      chk("small_cnt", s_cnt, m_cnt[3:0]);
   endtask

   // Steps forward with non-branching instructions until the model PC hits target.
   task automatic walk_to(input logic [31:0] target);
      while (m_pc != target) begin
         do_fetch(16'($urandom), $urandom_range(0, 2), 0);
         do_exec(0, 0, 1'($urandom), 0, 0, 0);
      end
   endtask

   initial begin
      model_reset();
      tick();
      tick();
      do_reset(0);

      // sequential addi with delayed ready
      do_fetch(16'h1045, 3, 0);
      do_exec(0, 0, 0, 1, 0, 0);
      chk("t2_pc", pc, 1);
      chk("t2_cnt", retire_cnt, 1);

      // beq taken from 5
      walk_to(32'd5);
      do_fetch(16'h5003, 0, 0);
      do_exec(1, 0, 1, 0, 0, 0);
      chk("beq_taken_addr", imem_addr, 9);

      // reset in EXEC with pending handshakes
      do_fetch(16'h2000, 1, 0);
      do_reset(1);

      walk_to(32'd5);
      do_fetch(16'h5003, 0, 0);
      do_exec(1, 0, 0, 0, 0, 0);
      chk("beq_not_taken_addr", imem_addr, 6);

      // bne backward from 10
      walk_to(32'd10);
      do_fetch(16'h603C, 0, 0);
      do_exec(0, 1, 0, 0, 0, 0);
      chk("bne_taken_addr", imem_addr, 7);
      walk_to(32'd10);
      do_fetch(16'h603C, 0, 0);
      do_exec(0, 1, 1, 0, 0, 0);
      chk("bne_not_taken_addr", imem_addr, 11);

      // wrap below zero, then wrap past max, with spurious handshakes
      do_reset(0);
      do_fetch(16'h503E, 2, 1);
      do_exec(1, 0, 1, 2, 1, 0);
      chk("wrap_neg", pc, 32'hFFFF_FFFF);
      do_fetch(16'h3001, 1, 1);
      do_exec(0, 0, 1, 1, 1, 1);
      chk("wrap_pos", pc, 0);
      do_fetch(16'h4002, 0, 0);
      do_exec(1, 1, 0, 0, 0, 0);
      chk("both_flags_taken", pc, 3);

      // opcode sweep, back-to-back
      do_reset(0);
      for (int op = 0; op < 16; op++) begin
         do_fetch({4'(op), 12'($urandom)}, 0, 0);
         do_exec(0, 0, 0, 0, 0, 0);
         if (op == 9) chk("sweep_cnt10", retire_cnt, 10);
      end
      chk("small_cnt_wrap", s_cnt, 0);

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         do_fetch(16'($urandom), $urandom_range(0, 3), 1'($urandom));
         do_exec(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
